// File: rtl/alu_seq_pkg.sv
// Shared constants for the multi-precision ALU sequencer and its users.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W     = 4;
  localparam int OP_LOGIC_BIT = 2;

  // Logic-path ops never propagate carry between nibbles.
  function automatic logic is_logic_op(input logic [2:0] op);
    return op[OP_LOGIC_BIT];
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Wide-word sequencer driving a 4-bit ALU one nibble per cycle, LSB first, chaining carry.
// Latency: rsp_valid rises NIBBLES cycles after the request acceptance edge.
// Backpressure: rsp_ready low holds DONE indefinitely; req_ready stays low until the cycle after the response handshake.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [W-1:0]        req_a,
  input  logic [W-1:0]        req_b,
  input  logic                req_cin,
  input  logic [2:0]          req_op,
  output logic [NIBBLE_W-1:0] alu_a,
  output logic [NIBBLE_W-1:0] alu_b,
  output logic                alu_cin,
  output logic [2:0]          alu_op,
  input  logic [NIBBLE_W-1:0] alu_r,
  input  logic                alu_carry,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_r,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic                rsp_sign
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t         state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   result;
  logic [2:0]     op_reg;
  logic           carry_reg;

  // Control FSM: latch the operation, walk the nibbles, then hold the result until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            op_reg    <= req_op;
            carry_reg <= is_logic_op(req_op) ? 1'b0 : req_cin;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          result[idx*NIBBLE_W +: NIBBLE_W] <= alu_r;
          carry_reg <= is_logic_op(op_reg) ? 1'b0 : alu_carry;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive: only the current nibble during RUN, otherwise quiet zeros.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_op  = '0;
    if (state == RUN) begin
      alu_a   = a_reg[idx*NIBBLE_W +: NIBBLE_W];
      alu_b   = b_reg[idx*NIBBLE_W +: NIBBLE_W];
      alu_cin = carry_reg;
      alu_op  = op_reg;
    end
  end

  // Handshake and flags decode purely from registered state, so they hold steady in DONE.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_r     = result;
  assign rsp_carry = carry_reg;
  assign rsp_zero  = (result == '0);
  assign rsp_sign  = result[W-1];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 4-bit ALU stub and a result scoreboard.
// Latency: checks rsp_valid exactly NIBBLES cycles after acceptance.
// Backpressure: holds rsp_ready low in DONE while a second request waits.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int NIB = 4;
  localparam int W   = NIBBLE_W * NIB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          req_cin;
  logic [2:0]    req_op;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic          alu_cin;
  logic [2:0]    alu_op;
  logic [3:0]    alu_r;
  logic          alu_carry;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_r;
  logic          rsp_carry;
  logic          rsp_zero;
  logic          rsp_sign;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         s;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_op    (alu_op),
    .alu_r     (alu_r),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .rsp_sign  (rsp_sign)
  );

  // Behavioural 4-bit ALU: add with carry on the arithmetic path, bitwise ops on the logic path.
  always_comb begin
    alu_r     = '0;
    alu_carry = 1'b0;
    if (!alu_op[OP_LOGIC_BIT]) begin
      {alu_carry, alu_r} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
    end else begin
      case (alu_op[1:0])
        2'b00:   alu_r = alu_a & alu_b;
        2'b01:   alu_r = alu_a | alu_b;
        default: alu_r = alu_a ^ alu_b;
      endcase
    end
  end

  // Whole-word reference result, computed without nibble slicing.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [2:0] op);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    if (!op[2]) begin
      s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.r = s[W-1:0];
      e.c = s[W];
    end else begin
      case (op[1:0])
        2'b00:   e.r = a & b;
        2'b01:   e.r = a | b;
        default: e.r = a ^ b;
      endcase
      e.c = 1'b0;
    end
    e.z = (e.r == '0);
    e.s = e.r[W-1];
    return e;
  endfunction

  // Carry into each nibble, recovered from the word sum as (a+b+cin)^a^b.
  function automatic logic [NIB-1:0] cin_seq(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic [2:0] op);
    logic [W-1:0]   x;
    logic [NIB-1:0] v;
    v = '0;
    if (!op[2]) begin
      x = (a + b + W'(cin)) ^ a ^ b;
      for (int k = 0; k < NIB; k++) v[k] = x[4*k];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_alu_a"},     32'(alu_a),     32'd0);
    chk({pfx, "_alu_b"},     32'(alu_b),     32'd0);
    chk({pfx, "_alu_cin"},   32'(alu_cin),   32'd0);
    chk({pfx, "_alu_op"},    32'(alu_op),    32'd0);
    chk({pfx, "_rsp_r"},     32'(rsp_r),     32'd0);
    chk({pfx, "_rsp_carry"}, 32'(rsp_carry), 32'd0);
    chk({pfx, "_rsp_zero"},  32'(rsp_zero),  32'd1);
    chk({pfx, "_rsp_sign"},  32'(rsp_sign),  32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the first RUN cycle with inputs scrambled.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [2:0] op, input bit push);
    int n;
    n = 0;
    req_a = a; req_b = b; req_cin = cin; req_op = op; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_at_send", 32'(req_ready), 32'd1);
    if (push) sb.push_back(model(a, b, cin, op));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a   = W'($urandom);
    req_b   = W'($urandom);
    req_cin = 1'($urandom);
    req_op  = 3'($urandom);
  endtask

  // Observes the NIB RUN cycles, then checks rsp_valid has just risen.
  task automatic watch_run(input logic [NIB-1:0] exp_cin, input logic [W-1:0] a);
    for (int k = 0; k < NIB; k++) begin
      chk($sformatf("alu_cin_n%0d", k), 32'(alu_cin), 32'(exp_cin[k]));
      chk($sformatf("alu_a_n%0d", k), 32'(alu_a), 32'(a[4*k +: 4]));
      chk($sformatf("rsp_valid_run_n%0d", k), 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
  endtask

  task automatic recv();
    int   n;
    exp_t e;
    n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_r",     32'(rsp_r),     32'(e.r));
      chk("rsp_carry", 32'(rsp_carry), 32'(e.c));
      chk("rsp_zero",  32'(rsp_zero),  32'(e.z));
      chk("rsp_sign",  32'(rsp_sign),  32'(e.s));
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e1;
    logic saw;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; req_op = '0;
    rsp_ready = 1'b0;
    reset = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Carry ripples through two nibbles; nibble carries 0,1,1,0.
    chk("cin_seq_model", 32'(cin_seq(16'h00FF, 16'h0001, 1'b0, 3'b000)), 32'h6);
    send(16'h00FF, 16'h0001, 1'b0, 3'b000, 1'b1);
    watch_run(cin_seq(16'h00FF, 16'h0001, 1'b0, 3'b000), 16'h00FF);
    recv();

    // Full overflow to zero.
    send(16'hFFFF, 16'h0001, 1'b0, 3'b000, 1'b1);
    watch_run(cin_seq(16'hFFFF, 16'h0001, 1'b0, 3'b000), 16'hFFFF);
    recv();

    // Carry-in only, sign bit set.
    send(16'h8000, 16'h0000, 1'b1, 3'b000, 1'b1);
    watch_run(cin_seq(16'h8000, 16'h0000, 1'b1, 3'b000), 16'h8000);
    recv();

    // Logic AND ignores cin and never carries.
    send(16'hF0F0, 16'h3C3C, 1'b1, 3'b100, 1'b1);
    watch_run(4'b0000, 16'hF0F0);
    recv();

    // Backpressure in DONE while a second request is already waiting.
    send(16'h1111, 16'h2222, 1'b0, 3'b000, 1'b1);
    watch_run(cin_seq(16'h1111, 16'h2222, 1'b0, 3'b000), 16'h1111);
    req_a = 16'hABCD; req_b = 16'h1234; req_cin = 1'b1; req_op = 3'b001; req_valid = 1'b1;
    e1 = sb[0];
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold_rsp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold_rsp_r_c%0d", c),     32'(rsp_r),     32'(e1.r));
      chk($sformatf("hold_rsp_carry_c%0d", c), 32'(rsp_carry), 32'(e1.c));
      chk($sformatf("hold_req_ready_c%0d", c), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    recv();
    sb.push_back(model(16'hABCD, 16'h1234, 1'b1, 3'b001));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    watch_run(cin_seq(16'hABCD, 16'h1234, 1'b1, 3'b001), 16'hABCD);
    recv();

    // Reset after two RUN cycles aborts the operation.
    send(16'h5555, 16'h2222, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw = saw | rsp_valid;
    end
    chk("no_rsp_after_abort", 32'(saw), 32'd0);

    send(16'h1234, 16'h1111, 1'b0, 3'b000, 1'b1);
    chk("post_abort_model", 32'(sb[sb.size()-1].r), 32'h2345);
    watch_run(cin_seq(16'h1234, 16'h1111, 1'b0, 3'b000), 16'h1234);
    recv();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
